// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper controller: FSM states, drive modes and the
// half-step coil table indexed by the 3-bit phase.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_WAVE     = 2'b00,
    MODE_FULL     = 2'b01,
    MODE_HALF     = 2'b10,
    MODE_FULL_ALT = 2'b11
  } mode_t;

  // Element [0] is phase 0 (rightmost in the concatenation).
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] coil_lut(input logic [2:0] phase);
    return COIL_TABLE[phase];
  endfunction

endpackage

// File: rtl/step_tick.sv
// Timing-tick prescaler: one tick every TICK_DIV enabled clk cycles,
// restartable with clr and frozen while en is low.
module step_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/stepper_ctrl.sv
// Stepper motor controller: accepts move commands, ramps the step interval at
// both ends of the move and sequences the coil pattern in wave/full/half mode.
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int PERIOD_W   = 12,
  parameter int POS_W      = 17,
  parameter int RAMP_STEPS = 8,
  parameter int HOLD_EN    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [POS_W-1:0]    cmd_steps,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                pause_i,
  input  logic                abort_i,
  output logic [3:0]          coil_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [POS_W-1:0]    position_o,
  output logic [1:0]          state_o
);

  localparam int RW   = $clog2(RAMP_STEPS + 1) + 1;
  localparam int IV_W = PERIOD_W + RW;

  state_t              state;
  mode_t               mode_r;
  logic                dir_r;
  logic [PERIOD_W-1:0] period_r;
  logic [POS_W-1:0]    steps_rem;
  logic [POS_W-1:0]    steps_taken;
  logic [POS_W-1:0]    position;
  logic [2:0]          phase;
  logic [3:0]          coil_r;
  logic                done_r;
  logic [IV_W-1:0]     tick_cnt;

  logic                accept;
  logic                tick_en;
  logic                tick;
  logic [POS_W-1:0]    rem_m1;
  logic [POS_W-1:0]    ramp_sub;
  logic [IV_W-1:0]     interval;
  logic [IV_W-1:0]     tick_nxt;
  logic                step_due;
  logic                mismatch;
  logic [2:0]          delta;
  logic [2:0]          phase_nxt;

  assign accept  = cmd_valid && (state == ST_IDLE);
  assign tick_en = (state == ST_RUN) && !pause_i && !abort_i;

  step_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (tick_en),
    .tick  (tick)
  );

  // Interval shrinks by one tick per step taken and grows again approaching the end.
  always_comb begin
    rem_m1   = steps_rem - POS_W'(1);
    ramp_sub = POS_W'(RAMP_STEPS);
    if (steps_taken < ramp_sub) ramp_sub = steps_taken;
    if (rem_m1 < ramp_sub)      ramp_sub = rem_m1;
    interval = IV_W'(period_r) + IV_W'(RAMP_STEPS) - IV_W'(ramp_sub);
    tick_nxt = tick_cnt + IV_W'(1);
    step_due = tick && (tick_nxt >= interval);
  end

  // Wave sits on even phases, full on odd; a parity mismatch realigns with a single half step.
  always_comb begin
    mismatch  = ((mode_r == MODE_WAVE) && phase[0]) ||
                (((mode_r == MODE_FULL) || (mode_r == MODE_FULL_ALT)) && !phase[0]);
    delta     = ((mode_r == MODE_HALF) || mismatch) ? 3'd1 : 3'd2;
    phase_nxt = dir_r ? phase + delta : phase - delta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_r      <= MODE_WAVE;
      dir_r       <= 1'b0;
      period_r    <= '0;
      steps_rem   <= '0;
      steps_taken <= '0;
      position    <= '0;
      phase       <= '0;
      coil_r      <= '0;
      done_r      <= 1'b0;
      tick_cnt    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_r       <= cmd_dir;
            mode_r      <= mode_t'(mode_i);
            period_r    <= (period_i == '0) ? PERIOD_W'(1) : period_i;
            steps_rem   <= cmd_steps;
            steps_taken <= '0;
            tick_cnt    <= '0;
            if (cmd_steps == '0) done_r <= 1'b1;
            else                 state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
            if (HOLD_EN == 0) coil_r <= 4'b0000;
          end else if (pause_i) begin
            state <= ST_PAUSE;
          end else if (step_due) begin
            tick_cnt    <= '0;
            phase       <= phase_nxt;
            position    <= dir_r ? position + POS_W'(1) : position - POS_W'(1);
            steps_rem   <= rem_m1;
            steps_taken <= steps_taken + POS_W'(1);
            if (steps_rem == POS_W'(1)) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
              coil_r <= (HOLD_EN != 0) ? coil_lut(phase_nxt) : 4'b0000;
            end else begin
              coil_r <= coil_lut(phase_nxt);
            end
          end else if (tick) begin
            tick_cnt <= tick_nxt;
          end
        end
        ST_PAUSE: begin
          if (abort_i) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
            if (HOLD_EN == 0) coil_r <= 4'b0000;
          end else if (!pause_i) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_r;
  assign coil_o     = coil_r;
  assign position_o = position;
  assign state_o    = state;

endmodule

// File: tb/tb_stepper_ctrl.sv
// Directed bench for stepper_ctrl: a vector table of commands plus hand-written
// sequences for reset, pause, abort and position wrap.
module tb_stepper_ctrl;
  import stepper_pkg::*;

  localparam int POS_W    = 17;
  localparam int PERIOD_W = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_dir = 1'b0;
  logic [POS_W-1:0]    cmd_steps = '0;
  logic [1:0]          mode_i = 2'b00;
  logic [PERIOD_W-1:0] period_i = '0;
  logic                pause_i = 1'b0;
  logic                abort_i = 1'b0;
  logic [3:0]          coil_o;
  logic                busy_o;
  logic                done_o;
  logic [POS_W-1:0]    position_o;
  logic [1:0]          state_o;

  logic                a_rst_n = 1'b0;
  logic                a_cmd_valid = 1'b0;
  logic                a_cmd_ready;
  logic                a_cmd_dir = 1'b0;
  logic [POS_W-1:0]    a_cmd_steps = '0;
  logic [1:0]          a_mode = 2'b00;
  logic [PERIOD_W-1:0] a_period = '0;
  logic                a_pause = 1'b0;
  logic                a_abort = 1'b0;
  logic [3:0]          a_coil;
  logic                a_busy;
  logic                a_done;
  logic [POS_W-1:0]    a_pos;
  logic [1:0]          a_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] coil_log[$];
  int         cyc_log[$];
  logic       busy_seen;

  typedef struct {
    logic [1:0]          mode;
    logic                dir;
    logic [POS_W-1:0]    steps;
    logic [PERIOD_W-1:0] period;
    logic [3:0]          exp_coil;
    int                  exp_pos;
    int                  exp_cyc;
  } vec_t;

  vec_t vecs [7];

  stepper_ctrl #(
    .TICK_DIV(4), .PERIOD_W(PERIOD_W), .POS_W(POS_W), .RAMP_STEPS(2), .HOLD_EN(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .mode_i(mode_i), .period_i(period_i),
    .pause_i(pause_i), .abort_i(abort_i), .coil_o(coil_o), .busy_o(busy_o),
    .done_o(done_o), .position_o(position_o), .state_o(state_o)
  );

  stepper_ctrl #(
    .TICK_DIV(1), .PERIOD_W(PERIOD_W), .POS_W(POS_W), .RAMP_STEPS(0), .HOLD_EN(0)
  ) u_alt (
    .clk(clk), .rst_n(a_rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_dir(a_cmd_dir), .cmd_steps(a_cmd_steps), .mode_i(a_mode), .period_i(a_period),
    .pause_i(a_pause), .abort_i(a_abort), .coil_o(a_coil), .busy_o(a_busy),
    .done_o(a_done), .position_o(a_pos), .state_o(a_state)
  );

  always #5 clk = ~clk;

  function automatic logic [POS_W-1:0] posOf(input int v);
    return POS_W'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic resetMain();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic startMain(input logic [1:0] mode, input logic dir,
                           input logic [POS_W-1:0] steps, input logic [PERIOD_W-1:0] period);
    @(negedge clk);
    cmd_valid = 1'b1;
    mode_i    = mode;
    cmd_dir   = dir;
    cmd_steps = steps;
    period_i  = period;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Issues a command and logs every coil change with its cycle offset from accept.
  task automatic applyStimulus(input logic [1:0] mode, input logic dir,
                               input logic [POS_W-1:0] steps,
                               input logic [PERIOD_W-1:0] period, output int cyc);
    logic [3:0] prev;
    prev = coil_o;
    startMain(mode, dir, steps, period);
    coil_log.delete();
    cyc_log.delete();
    busy_seen = busy_o;
    cyc = 0;
    while (!done_o && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy_o) busy_seen = 1'b1;
      if (coil_o != prev) begin
        coil_log.push_back(coil_o);
        cyc_log.push_back(cyc);
      end
      prev = coil_o;
    end
    checkOutput("done_reached", done_o, 1);
  endtask

  task automatic aStart(input logic [1:0] mode, input logic dir,
                        input logic [POS_W-1:0] steps, input logic [PERIOD_W-1:0] period);
    @(negedge clk);
    a_cmd_valid = 1'b1;
    a_mode      = mode;
    a_cmd_dir   = dir;
    a_cmd_steps = steps;
    a_period    = period;
    @(posedge clk);
    #1;
    a_cmd_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int hold_bad;
    int moves;
    logic done_seen;
    logic [3:0] held_coil;
    logic [POS_W-1:0] held_pos;
    logic [POS_W-1:0] prev_pos;

    vecs[0] = '{MODE_WAVE,     1'b1, 17'd3, 12'd1, 4'b0100,  1, 32};
    vecs[1] = '{MODE_HALF,     1'b0, 17'd5, 12'd2, 4'b0011, -4, 64};
    vecs[2] = '{MODE_FULL_ALT, 1'b1, 17'd4, 12'd1, 4'b0011,  0, 40};
    vecs[3] = '{MODE_WAVE,     1'b0, 17'd2, 12'd0, 4'b0100, -2, 24};
    vecs[4] = '{MODE_FULL,     1'b0, 17'd3, 12'd3, 4'b0011, -5, 56};
    vecs[5] = '{MODE_HALF,     1'b1, 17'd0, 12'd1, 4'b0011, -5,  0};
    vecs[6] = '{MODE_HALF,     1'b1, 17'd1, 12'd1, 4'b0001, -4, 12};

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_coil", coil_o, 0);
    checkOutput("rst_pos", position_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("alt_rst_ready", a_cmd_ready, 1);
    rst_n = 1'b1;
    a_rst_n = 1'b1;

    // Half-step ramp: intervals 3,2,3 ticks of 4 clocks each.
    applyStimulus(MODE_HALF, 1'b1, 17'd3, 12'd1, cyc);
    checkOutput("ramp_nsteps", coil_log.size(), 3);
    if (coil_log.size() == 3) begin
      checkOutput("ramp_coil0", coil_log[0], 4'b1100);
      checkOutput("ramp_coil1", coil_log[1], 4'b0100);
      checkOutput("ramp_coil2", coil_log[2], 4'b0110);
      checkOutput("ramp_cyc0", cyc_log[0], 12);
      checkOutput("ramp_cyc1", cyc_log[1], 20);
      checkOutput("ramp_cyc2", cyc_log[2], 32);
    end
    checkOutput("ramp_pos", position_o, 3);
    checkOutput("ramp_busy_seen", busy_seen, 1);
    @(posedge clk); #1;
    checkOutput("ramp_done_width", done_o, 0);

    // Reset in the middle of a move abandons it silently.
    startMain(MODE_HALF, 1'b1, 17'd10, 12'd1);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_state", state_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_coil", coil_o, 0);
    checkOutput("midrst_pos", position_o, 0);
    checkOutput("midrst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_o) done_seen = 1'b1;
    end
    checkOutput("midrst_no_done", done_seen, 0);

    // Full mode backward from phase 0: single-step realignment, then double steps.
    applyStimulus(MODE_FULL, 1'b0, 17'd2, 12'd1, cyc);
    checkOutput("full_nsteps", coil_log.size(), 2);
    if (coil_log.size() == 2) begin
      checkOutput("full_coil0", coil_log[0], 4'b1001);
      checkOutput("full_coil1", coil_log[1], 4'b0011);
    end
    checkOutput("full_pos", position_o, posOf(-2));

    // Vector table continues from phase 5, position -2.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].dir, vecs[i].steps, vecs[i].period, cyc);
      checkOutput($sformatf("vec%0d_cyc", i), cyc, vecs[i].exp_cyc);
      checkOutput($sformatf("vec%0d_coil", i), coil_o, vecs[i].exp_coil);
      checkOutput($sformatf("vec%0d_pos", i), position_o, posOf(vecs[i].exp_pos));
      checkOutput($sformatf("vec%0d_busy_seen", i), busy_seen, (vecs[i].steps != 0));
      checkOutput($sformatf("vec%0d_state", i), state_o, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_done_width", i), done_o, 0);
    end

    // Pause for 20 cycles after step 4 of 10.
    resetMain();
    startMain(MODE_HALF, 1'b1, 17'd10, 12'd1);
    cyc = 0;
    while (position_o != 4 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("pause_reach4", position_o, 4);
    pause_i = 1'b1;
    held_coil = coil_o;
    held_pos = position_o;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (coil_o != held_coil || position_o != held_pos || state_o != 2'd2) hold_bad++;
    end
    checkOutput("pause_hold_violations", hold_bad, 0);
    pause_i = 1'b0;
    moves = 0;
    prev_pos = position_o;
    cyc = 0;
    while (!done_o && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      if (position_o != prev_pos) moves++;
      prev_pos = position_o;
    end
    checkOutput("pause_done", done_o, 1);
    checkOutput("pause_moves_after", moves, 6);
    checkOutput("pause_pos", position_o, 10);
    checkOutput("pause_coil", coil_o, 4'b0100);

    // Abort together with pause after step 2; then accept with abort held in IDLE.
    resetMain();
    startMain(MODE_HALF, 1'b1, 17'd10, 12'd1);
    cyc = 0;
    while (position_o != 2 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    abort_i = 1'b1;
    pause_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_state", state_o, 0);
    checkOutput("abort_done", done_o, 1);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_pos", position_o, 2);
    checkOutput("abort_coil_hold", coil_o, 4'b0100);
    @(posedge clk); #1;
    checkOutput("abort_done_width", done_o, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_more_steps", position_o, 2);
    startMain(MODE_HALF, 1'b1, 17'd1, 12'd1);
    checkOutput("abort_idle_accept_busy", busy_o, 1);
    abort_i = 1'b0;
    pause_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("abort_idle_accept_done", done_o, 1);
    checkOutput("abort_idle_accept_pos", position_o, 3);

    // HOLD_EN=0 instance: abort releases the coils.
    aStart(MODE_HALF, 1'b1, 17'd10, 12'd4);
    cyc = 0;
    while (a_pos != 2 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("alt_step2_cyc", cyc, 8);
    checkOutput("alt_running_coil", a_coil, 4'b0100);
    a_abort = 1'b1;
    a_pause = 1'b1;
    @(posedge clk); #1;
    checkOutput("alt_abort_state", a_state, 0);
    checkOutput("alt_abort_done", a_done, 1);
    checkOutput("alt_abort_pos", a_pos, 2);
    checkOutput("alt_abort_coil", a_coil, 4'b0000);
    a_abort = 1'b0;
    a_pause = 1'b0;

    // Position wraps only at 2^17.
    @(negedge clk);
    a_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    aStart(MODE_HALF, 1'b1, 17'd65535, 12'd1);
    cyc = 0;
    while (!a_done && cyc < 70000) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("wrap_done", a_done, 1);
    checkOutput("wrap_cyc", cyc, 65535);
    checkOutput("wrap_pos65535", a_pos, 17'd65535);
    aStart(MODE_HALF, 1'b1, 17'd2, 12'd1);
    @(posedge clk); #1;
    checkOutput("wrap_pos65536", a_pos, 17'h10000);
    checkOutput("wrap_signed1", int'($signed(a_pos)), -65536);
    @(posedge clk); #1;
    checkOutput("wrap_pos65537", a_pos, 17'h10001);
    checkOutput("wrap_signed2", int'($signed(a_pos)), -65535);
    checkOutput("wrap_done2", a_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_ctrl.md
STEPPER_CTRL -- requirements
Module: stepper_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per timing tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter PERIOD_W, default 12, width of step-interval field in ticks.
REQ-003 SHALL have parameter POS_W, default 17, width of step count and position.
REQ-004 SHALL have parameter RAMP_STEPS, default 8, accel/decel ramp length in steps.
REQ-005 SHALL have parameter HOLD_EN, default 1; 1 holds the last coil pattern when idle, 0 drives 0000.
REQ-006 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
REQ-007 SHALL have these ports:
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_dir  in  1  1 = forward, 0 = backward
- cmd_steps  in  POS_W  unsigned step count
- mode_i  in  2  00 = wave, 01 = full, 10 = half, 11 = full
- period_i  in  PERIOD_W  minimum ticks per step; 0 is treated as 1
- pause_i  in  1  freeze motion
- abort_i  in  1  terminate the command
- coil_o  out  4  coil drive pattern
- busy_o  out  1  command active
- done_o  out  1  one-cycle completion pulse
- position_o  out  POS_W  signed step position
- state_o  out  2  FSM state, for debug

Function
REQ-008 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2; encoding 3 is unused and SHALL go to IDLE.
REQ-009 SHALL assert cmd_ready only in IDLE; on accept SHALL latch dir, steps, mode and period, and set busy_o on the next edge.
REQ-010 SHALL treat cmd_steps=0 as accepted with no motion: done_o pulses 1 cycle after accept and the FSM stays in IDLE.
REQ-011 SHALL generate a tick every TICK_DIV clk cycles; the prescaler restarts at accept and is frozen in PAUSE.
REQ-012 SHALL compute step interval = period + RAMP_STEPS - min(RAMP_STEPS, steps_taken, steps_remaining-1), in ticks.
REQ-013 SHALL take one step when the tick count reaches the interval, then restart the interval count.
REQ-014 SHALL use an 8-entry half-step table indexed by a 3-bit phase: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-015 SHALL step the phase as follows: half mode ±1; wave mode uses even phases only; full mode uses odd phases only; the phase wraps mod 8.
REQ-016 SHALL make the first step of a wave/full command a ±1 move when the phase parity mismatches the mode, else ±2.
REQ-017 SHALL, on each step, update coil_o, position ±1 (two's-complement wrap) and steps_remaining -1, all on the same edge.
REQ-018 SHALL, on the edge applying the last step, go to IDLE, clear busy_o and pulse done_o on the next cycle.
REQ-019 SHALL, with pause_i high in RUN, enter PAUSE at the next edge and hold coils and all counters; when pause_i falls, SHALL resume RUN with the interval count preserved.
REQ-020 SHALL, with abort_i in RUN or PAUSE, go to IDLE at the next edge without a further step and pulse done_o; abort wins over pause and over step-due.
REQ-021 SHALL ignore abort_i and pause_i in IDLE; cmd_valid with abort_i in the same IDLE cycle SHALL still be accepted.
REQ-022 SHALL ignore changes on mode_i, period_i and cmd_* while busy.
REQ-023 SHALL, in IDLE with HOLD_EN=0, drive coil_o=0000 while keeping the phase register.

Reset
REQ-024 SHALL, on rst_n low, immediately set: FSM=IDLE, phase=0, coil_o=0000, position_o=0, busy_o=0, done_o=0, cmd_ready=1, prescaler and counters=0.
REQ-025 SHALL, on reset during RUN, abandon the command with no done_o pulse.

Structure
REQ-026 SHALL place the mode encodings, the state encoding and the 8-entry coil table in the shared package stepper_pkg.
REQ-027 SHALL implement the tick prescaler as the sub-module step_tick (ports: clk, rst_n, clr, en, tick).

Verification
REQ-028 SHALL cover (TICK_DIV=4, RAMP=2): half, fwd, steps=3, period=1 -> intervals 3, 2, 3 ticks; coils 1100, 0100, 0110; position 3; one done_o pulse.
REQ-029 SHALL cover: phase 0, full, back, steps=2 -> coils 1001 (±1 alignment) then 0011; position -2.
REQ-030 SHALL cover: steps=0 -> done_o 1 cycle after accept; busy_o never high; coil_o unchanged.
REQ-031 SHALL cover: steps=10 with pause for 20 cycles after step 4 -> no coil change while paused; 6 steps remain after release; total position 10.
REQ-032 SHALL cover: abort together with pause after step 2 of 10 -> IDLE next edge, done_o pulse, position 2; HOLD_EN=0 gives coil_o=0000.
REQ-033 SHALL cover: position at 65535 (POS_W=17), fwd 2 steps -> 65536 (-65536 signed), then 65537 (-65535 signed); wrap only at 2^17.
